dvs_gesture_event_gen: RTL and testbench
========================================

DVS_GESTURE_EVENT_GEN -- requirements
Module: dvs_gesture_event_gen

Interface
REQ-001 SHALL have parameter WIDTH_P, default 8, sensor columns.
REQ-002 SHALL have parameter HEIGHT_P, default 8, sensor rows.
REQ-003 SHALL have parameter GAP_CYCLES_P, default 4, idle cycles between sweep steps; legal range 0..255.
REQ-004 SHALL have port clk_i, input, 1, single clock; all logic rising-edge.
REQ-005 SHALL have port reset_i, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port start_i, input, 1, begin one gesture sweep.
REQ-007 SHALL have port gesture_idx_i, input, 2, sweep direction: 0 right, 1 left, 2 down, 3 up.
REQ-008 SHALL have port busy_o, output, 1, sweep in progress.
REQ-009 SHALL have port done_o, output, 1, one-cycle pulse at sweep end.
REQ-010 SHALL have port valid_o, output, 1, event valid.
REQ-011 SHALL have port ready_i, input, 1, downstream accepts event.
REQ-012 SHALL have port x_o, output, $clog2(WIDTH_P), event column.
REQ-013 SHALL have port y_o, output, $clog2(HEIGHT_P), event row.
REQ-014 SHALL have port polarity_o, output, 1, 1 = ON, 0 = OFF.
REQ-015 SHALL have port timestamp_o, output, 16, event timestamp.

Function
REQ-016 SHALL implement states IDLE, EMIT_ON, EMIT_OFF, GAP, DONE.
REQ-017 IDLE: start_i=1 latches gesture_idx_i, enters EMIT_ON at step 0, asserts busy_o next cycle; start_i is ignored in every other state.
REQ-018 Horizontal sweeps (0/1) SHALL step over columns: 0 uses x=0..WIDTH_P-1, 1 uses x=WIDTH_P-1..0; each step emits HEIGHT_P events, y ascending.
REQ-019 Vertical sweeps (2/3) SHALL step over rows: 2 uses y=0..HEIGHT_P-1, 3 uses y=HEIGHT_P-1..0; each step emits WIDTH_P events, x ascending.
REQ-020 EMIT_ON SHALL emit polarity 1 for the current line; then EMIT_OFF emits polarity 0 for the previous line; EMIT_OFF is skipped at step 0.
REQ-021 After the last step's EMIT_OFF, one extra EMIT_OFF SHALL emit polarity 0 for the final line, then go to DONE; total events = 2*WIDTH_P*HEIGHT_P.
REQ-022 GAP SHALL hold valid_o=0 for GAP_CYCLES_P cycles between steps; with GAP_CYCLES_P=0 it is bypassed.
REQ-023 valid_o SHALL NOT depend combinationally on ready_i; once asserted, valid_o, x_o, y_o, polarity_o and timestamp_o SHALL stay stable until the cycle valid_o&&ready_i.
REQ-024 A handshake SHALL present the next event on the following cycle, so the stream is back-to-back at full throughput.
REQ-025 A free-running 16-bit timestamp counter SHALL increment every cycle and wrap 65535->0; timestamp_o = counter value in the cycle the event is first presented.
REQ-026 DONE SHALL pulse done_o for one cycle, drop busy_o and return to IDLE; a start_i in that cycle is ignored.
REQ-027 Outside an active event, x_o, y_o, polarity_o and timestamp_o SHALL be 0.

Reset
REQ-028 reset_i SHALL force IDLE, valid_o=0, busy_o=0, done_o=0, all data outputs 0, timestamp counter 0 and LFSR to its seed on the next edge; reset wins over every other input.
REQ-029 Reset mid-sweep SHALL abandon the sweep with no further events; the next start_i begins a fresh sequence.

Configuration
REQ-030 With macro DVS_GEN_NOISE_EN defined, one noise event SHALL be emitted after each EMIT_ON phase, using an 8-bit LFSR (seed 8'hA5, taps x^8+x^6+x^5+x^4+1) advanced once per noise event: x = lfsr mod WIDTH_P, y = (lfsr>>4) mod HEIGHT_P, polarity = lfsr[7]; total events then increase by the step count.
REQ-031 Without DVS_GEN_NOISE_EN, no LFSR or noise logic SHALL exist and the event count SHALL be exactly 2*WIDTH_P*HEIGHT_P.

Verification
REQ-032 Default params, GAP_CYCLES_P=0, ready_i=1, start gesture 0 -> events (0,0..7,ON), (1,0..7,ON), (0,0..7,OFF), ...; 128 handshakes, last is (7,7,OFF); one done_o pulse.
REQ-033 ready_i held low 5 cycles while the 3rd event is presented -> valid_o and all fields unchanged for 5 cycles; no lost or duplicated events; total still 128.
REQ-034 Gesture 3 -> first event (x0,y7,ON), last event (x7,y0,OFF); gesture 1 -> first (x7,y0,ON).
REQ-035 start_i pulsed with gesture_idx_i=0 during a gesture-2 sweep -> ignored; sweep stays vertical, exactly 128 events.
REQ-036 Release reset, wait 65530 cycles, start -> timestamps wrap 65535->0 and increase by 1 per back-to-back event modulo 2^16.
REQ-037 Assert reset_i after 20 handshakes -> valid_o=0 and busy_o=0 on the next edge; a new start yields the first event (0,0,ON) with timestamp equal to the counter value.

Source files
------------

// File: rtl/dvs_gesture_event_gen.sv
// dvs_gesture_event_gen
//   Synthetic DVS (event camera) stimulus source. It sweeps a bar across a
//   WIDTH_P x HEIGHT_P sensor and emits ON events for the line the bar
//   enters and OFF events for the line it leaves. Events go out on a
//   valid/ready stream, each stamped with a free-running 16-bit cycle counter.
//
//   Ports
//     clk_i          single rising-edge clock
//     reset_i        synchronous active-high reset
//     start_i        begin one sweep (only looked at in IDLE)
//     gesture_idx_i  sweep direction: 0 right, 1 left, 2 down, 3 up
//     busy_o         sweep in progress
//     done_o         one-cycle pulse at sweep end
//     valid_o        event valid (registered state, never depends on ready_i)
//     ready_i        downstream accepts event
//     x_o, y_o       event column / row
//     polarity_o     1 = ON, 0 = OFF
//     timestamp_o    counter value when the event was first presented
//
//   Optional build macro DVS_GEN_NOISE_EN adds one pseudo-random noise event
//   after each ON line, driven by an 8-bit LFSR (seed 8'hA5).
//
//   state    | meaning
//   IDLE     | waiting for start_i
//   EMIT_ON  | ON events for the line of the current step
//   NOISE    | one LFSR noise event (DVS_GEN_NOISE_EN builds only)
//   EMIT_OFF | OFF events for the previous line, or the final line
//   GAP      | idle cycles between steps
//   DONE     | done_o pulse, back to IDLE
module dvs_gesture_event_gen #(
  parameter int WIDTH_P      = 8,
  parameter int HEIGHT_P     = 8,
  parameter int GAP_CYCLES_P = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  input  logic [1:0]                  gesture_idx_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [$clog2(WIDTH_P)-1:0]  x_o,
  output logic [$clog2(HEIGHT_P)-1:0] y_o,
  output logic                        polarity_o,
  output logic [15:0]                 timestamp_o
);

  localparam int XW   = $clog2(WIDTH_P);
  localparam int YW   = $clog2(HEIGHT_P);
  localparam int MAXD = (WIDTH_P > HEIGHT_P) ? WIDTH_P : HEIGHT_P;
  localparam int CW   = $clog2(MAXD + 1);

  localparam logic [CW-1:0] W_LAST   = CW'(WIDTH_P - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(HEIGHT_P - 1);
  localparam logic [7:0]    GAP_LOAD = 8'((GAP_CYCLES_P > 0) ? GAP_CYCLES_P - 1 : 0);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_EMIT_ON  = 3'd1;
  localparam logic [2:0] ST_EMIT_OFF = 3'd2;
  localparam logic [2:0] ST_GAP      = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;
`ifdef DVS_GEN_NOISE_EN
  localparam logic [2:0]  ST_NOISE = 3'd5;
  localparam logic [31:0] WIDTH_U  = 32'(WIDTH_P);
  localparam logic [31:0] HEIGHT_U = 32'(HEIGHT_P);
`endif

  logic [2:0]    state_q, state_d;
  logic [1:0]    gesture_q, gesture_d;
  logic [CW-1:0] step_q, step_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          final_q, final_d;
  logic [7:0]    gap_q, gap_d;
  logic [15:0]   ts_cnt_q;
  logic [15:0]   ts_q;
`ifdef DVS_GEN_NOISE_EN
  logic [7:0]    lfsr_q;
`endif

  logic          emitting;
  logic          hs;
  logic          vertical;
  logic [CW-1:0] step_last, idx_last;
  logic [CW-1:0] line_step, line_idx;
  logic [CW-1:0] ev_x, ev_y;
  logic          on_end;
  logic          adv;

  // Geometry of the current event. An OFF phase normally clears the line
  // left behind (step-1); the closing OFF phase clears the last line itself.
  always_comb begin
    vertical  = gesture_q[1];
    step_last = vertical ? H_LAST : W_LAST;
    idx_last  = vertical ? W_LAST : H_LAST;
    line_step = (state_q == ST_EMIT_OFF && !final_q) ? step_q - CW'(1) : step_q;
    line_idx  = gesture_q[0] ? step_last - line_step : line_step;
    ev_x      = vertical ? idx_q : line_idx;
    ev_y      = vertical ? line_idx : idx_q;
  end

  always_comb begin
    emitting = (state_q == ST_EMIT_ON) || (state_q == ST_EMIT_OFF);
`ifdef DVS_GEN_NOISE_EN
    emitting = emitting || (state_q == ST_NOISE);
`endif
    x_o         = '0;
    y_o         = '0;
    polarity_o  = 1'b0;
    timestamp_o = '0;
    if (emitting) begin
      x_o         = XW'(ev_x);
      y_o         = YW'(ev_y);
      polarity_o  = (state_q == ST_EMIT_ON);
      timestamp_o = ts_q;
`ifdef DVS_GEN_NOISE_EN
      if (state_q == ST_NOISE) begin
        x_o        = XW'({24'd0, lfsr_q} % WIDTH_U);
        y_o        = YW'({28'd0, lfsr_q[7:4]} % HEIGHT_U);
        polarity_o = lfsr_q[7];
      end
`endif
    end
  end

  assign valid_o = emitting;
  assign hs      = valid_o && ready_i;
  assign busy_o  = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o  = (state_q == ST_DONE);

  // End of the ON part of a step: the last ON event, or the noise event
  // that follows it when noise is built in.
`ifdef DVS_GEN_NOISE_EN
  assign on_end = (state_q == ST_NOISE) && hs;
`else
  assign on_end = (state_q == ST_EMIT_ON) && hs && (idx_q == idx_last);
`endif

  always_comb begin
    state_d   = state_q;
    gesture_d = gesture_q;
    step_d    = step_q;
    idx_d     = idx_q;
    final_d   = final_q;
    gap_d     = gap_q;
    adv       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          gesture_d = gesture_idx_i;
          step_d    = '0;
          idx_d     = '0;
          final_d   = 1'b0;
          state_d   = ST_EMIT_ON;
        end
      end
      ST_EMIT_ON: begin
        if (hs) begin
          if (idx_q == idx_last) begin
            idx_d = '0;
`ifdef DVS_GEN_NOISE_EN
            state_d = ST_NOISE;
`endif
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      ST_EMIT_OFF: begin
        if (hs) begin
          if (idx_q == idx_last) begin
            idx_d = '0;
            if (final_q) begin
              state_d = ST_DONE;
            end else if (step_q == step_last) begin
              final_d = 1'b1;
            end else begin
              adv = 1'b1;
            end
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      ST_GAP: begin
        if (gap_q == 8'd0) begin
          state_d = ST_EMIT_ON;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Step 0 has no previous line to clear; a single-step sweep goes
    // straight to the closing OFF phase.
    if (on_end) begin
      if (step_q != '0) begin
        state_d = ST_EMIT_OFF;
      end else if (step_q == step_last) begin
        state_d = ST_EMIT_OFF;
        final_d = 1'b1;
      end else begin
        adv = 1'b1;
      end
    end

    if (adv) begin
      step_d  = step_q + CW'(1);
      gap_d   = GAP_LOAD;
      state_d = (GAP_CYCLES_P == 0) ? ST_EMIT_ON : ST_GAP;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      gesture_q <= 2'd0;
      step_q    <= '0;
      idx_q     <= '0;
      final_q   <= 1'b0;
      gap_q     <= 8'd0;
      ts_cnt_q  <= 16'd0;
      ts_q      <= 16'd0;
    end else begin
      state_q   <= state_d;
      gesture_q <= gesture_d;
      step_q    <= step_d;
      idx_q     <= idx_d;
      final_q   <= final_d;
      gap_q     <= gap_d;
      ts_cnt_q  <= ts_cnt_q + 16'd1;
      // Capture the counter value of the cycle in which the next event
      // appears; held while an event waits for ready_i.
      if (!valid_o || hs) begin
        ts_q <= ts_cnt_q + 16'd1;
      end
    end
  end

`ifdef DVS_GEN_NOISE_EN
  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, stepped once per accepted noise event.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lfsr_q <= 8'hA5;
    end else if (state_q == ST_NOISE && hs) begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end
`endif

endmodule

// File: tb/tb_dvs_gesture_event_gen.sv
module tb_dvs_gesture_event_gen;

  logic        clk;
  logic        rst;
  logic        start, start2;
  logic [1:0]  gest;
  logic        ready;
  logic        busy, done, valid, pol;
  logic [2:0]  x, y;
  logic [15:0] ts;
  logic        busy2, done2, valid2, pol2;
  logic [2:0]  x2, y2;
  logic [15:0] ts2;

  logic [15:0] m_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  int ex_x[0:255];
  int ex_y[0:255];
  int ex_p[0:255];
  int n_exp;
  bit last_wrapped;

  dvs_gesture_event_gen #(.WIDTH_P(8), .HEIGHT_P(8), .GAP_CYCLES_P(0)) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .gesture_idx_i(gest),
    .busy_o(busy), .done_o(done), .valid_o(valid), .ready_i(ready),
    .x_o(x), .y_o(y), .polarity_o(pol), .timestamp_o(ts)
  );

  dvs_gesture_event_gen #(.WIDTH_P(8), .HEIGHT_P(8), .GAP_CYCLES_P(2)) dut_gap (
    .clk_i(clk), .reset_i(rst), .start_i(start2), .gesture_idx_i(2'd0),
    .busy_o(busy2), .done_o(done2), .valid_o(valid2), .ready_i(1'b1),
    .x_o(x2), .y_o(y2), .polarity_o(pol2), .timestamp_o(ts2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference for the free-running timestamp counter.
  always @(posedge clk) begin
    if (rst) m_cnt <= 16'd0;
    else     m_cnt <= m_cnt + 16'd1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int line_of(input logic [1:0] g, input int s);
    return g[0] ? 7 - s : s;
  endfunction

  task automatic add_line(input logic [1:0] g, input int ln, input int p);
    for (int i = 0; i < 8; i++) begin
      ex_x[n_exp] = g[1] ? i : ln;
      ex_y[n_exp] = g[1] ? ln : i;
      ex_p[n_exp] = p;
      n_exp++;
    end
  endtask

  task automatic build_exp(input logic [1:0] g);
    n_exp = 0;
    for (int s = 0; s < 8; s++) begin
      add_line(g, line_of(g, s), 1);
      if (s > 0) add_line(g, line_of(g, s - 1), 0);
    end
    add_line(g, line_of(g, 7), 0);
  endtask

  // Runs one sweep on the gap-free instance; caller is at a negedge.
  task automatic run_sweep(input logic [1:0] g, input int stall_ev, input int stall_len,
                           input int inject_at, input int abort_at, input bit done_start);
    int n = 0;
    int stall_cnt = 0;
    int cyc = 0;
    int dones = 0;
    bit held = 0;
    bit stall_ok = 1;
    bit injected = 0;
    bit have_prev = 0;
    logic [15:0] prev_ts;
    logic [25:0] snap;
    build_exp(g);
    last_wrapped = 0;
    start = 1'b1;
    gest  = g;
    @(negedge clk);
    start = 1'b0;
    gest  = ~g;
    check_val("busy_after_start", busy, 1);
    while (cyc < 3000) begin
      cyc++;
      if (done) begin
        dones++;
        break;
      end
      ready = !(n == stall_ev && stall_cnt < stall_len);
      if (!ready) stall_cnt++;
      if (valid) begin
        if (!held) begin
          held = 1;
          snap = {x, y, pol, ts, valid, 3'd0};
          check_val("ts_first", ts, m_cnt);
        end else if ({x, y, pol, ts, valid, 3'd0} !== snap) begin
          stall_ok = 0;
        end
        if (ready) begin
          if (n < n_exp) begin
            check_val("ev_x", x, ex_x[n]);
            check_val("ev_y", y, ex_y[n]);
            check_val("ev_pol", pol, ex_p[n]);
          end else begin
            check_val("extra_event", n, n_exp);
          end
          if (have_prev && ts < prev_ts) last_wrapped = 1;
          prev_ts   = ts;
          have_prev = 1;
          n++;
          held = 0;
          if (n == abort_at) begin
            rst = 1'b1;
            break;
          end
        end
      end
      if (!injected && inject_at >= 0 && n == inject_at) begin
        start    = 1'b1;
        gest     = 2'd0;
        injected = 1;
      end
      @(negedge clk);
      start = 1'b0;
    end
    ready = 1'b1;
    if (abort_at >= 0) begin
      check_val("abort_count", n, abort_at);
    end else begin
      check_val("event_count", n, n_exp);
      check_val("done_pulse", dones, 1);
      check_val("hold_stable", stall_ok, 1);
      if (dones > 0) begin
        check_val("busy_in_done", busy, 0);
        if (done_start) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("done_one_cycle", done, 0);
        check_val("busy_after_done", busy, 0);
        @(negedge clk);
        check_val("start_in_done_ignored", busy, 0);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_valid"}, valid, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_fields"}, {x, y, pol, ts}, 0);
  endtask

  initial begin
    int busy_cyc, v_cyc, d2;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; gest = 2'd0; ready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle("idle");

    run_sweep(2'd0, -1, 0, -1, -1, 1'b1);
    run_sweep(2'd0, 2, 5, -1, -1, 1'b0);
    run_sweep(2'd3, -1, 0, -1, -1, 1'b0);
    run_sweep(2'd1, -1, 0, -1, -1, 1'b0);
    run_sweep(2'd2, -1, 0, 30, -1, 1'b0);

    // Sweep with two gap cycles between steps: 128 events + 7 gaps * 2.
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    busy_cyc = 0; v_cyc = 0; d2 = 0;
    for (int c = 0; c < 400 && d2 == 0; c++) begin
      if (busy2) busy_cyc++;
      if (valid2) begin
        v_cyc++;
        if (v_cyc == 128) begin
          check_val("gap_last_xy", {x2, y2}, {3'd7, 3'd7});
          check_val("gap_last_pol", pol2, 0);
          check_val("gap_last_ts", ts2, m_cnt);
        end
      end
      if (done2) d2 = 1;
      @(negedge clk);
    end
    check_val("gap_busy_cycles", busy_cyc, 142);
    check_val("gap_event_count", v_cyc, 128);
    check_val("gap_done", d2, 1);

    // Reset in the middle of a sweep, then a fresh sweep.
    run_sweep(2'd0, -1, 0, -1, 20, 1'b0);
    @(negedge clk);
    check_val("abort_valid", valid, 0);
    check_val("abort_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_abort");
    run_sweep(2'd0, -1, 0, -1, -1, 1'b0);

    // Timestamp wrap.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (65530) @(negedge clk);
    run_sweep(2'd0, -1, 0, -1, -1, 1'b0);
    check_val("ts_wrapped", last_wrapped, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
